// File: rtl/segment_pkg.sv
// 7-segment pattern types and active-low decimal glyph table, shared by the encoder and decoder sides.
// Bit map: 0 top, 1 up-right, 2 low-right, 3 bottom, 4 low-left, 5 up-left, 6 middle; 0 = lit.
package segment_pkg;

  typedef logic [6:0] seg_pattern_t;

  typedef struct packed {
    logic [3:0] value;
    logic       blank;
    logic       illegal;
  } seg_dec_t;

  localparam seg_pattern_t SEG_0     = 7'h40;
  localparam seg_pattern_t SEG_1     = 7'h79;
  localparam seg_pattern_t SEG_2     = 7'h24;
  localparam seg_pattern_t SEG_3     = 7'h30;
  localparam seg_pattern_t SEG_4     = 7'h19;
  localparam seg_pattern_t SEG_5     = 7'h12;
  localparam seg_pattern_t SEG_6     = 7'h02;
  localparam seg_pattern_t SEG_7     = 7'h78;
  localparam seg_pattern_t SEG_8     = 7'h00;
  localparam seg_pattern_t SEG_9     = 7'h10;
  localparam seg_pattern_t SEG_BLANK = 7'h7F;

  localparam logic [3:0] DIG_BLANK   = 4'hF;
  localparam logic [3:0] DIG_ILLEGAL = 4'hE;

endpackage

// File: rtl/segment_pattern_dec.sv
// Decodes one active-low 7-segment pattern back to a BCD value with blank/illegal flags.
// Latency: combinational; backpressure: none.
module segment_pattern_dec
  import segment_pkg::*;
(
  input  seg_pattern_t pat,
  output seg_dec_t     dec
);

  always_comb begin
    dec.value   = DIG_ILLEGAL;
    dec.blank   = 1'b0;
    dec.illegal = 1'b0;
    case (pat)
      SEG_0:     dec.value = 4'd0;
      SEG_1:     dec.value = 4'd1;
      SEG_2:     dec.value = 4'd2;
      SEG_3:     dec.value = 4'd3;
      SEG_4:     dec.value = 4'd4;
      SEG_5:     dec.value = 4'd5;
      SEG_6:     dec.value = 4'd6;
      SEG_7:     dec.value = 4'd7;
      SEG_8:     dec.value = 4'd8;
      SEG_9:     dec.value = 4'd9;
      SEG_BLANK: begin
        dec.value = DIG_BLANK;
        dec.blank = 1'b1;
      end
      default:   dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/segment_scan_dec.sv
// Snoops a multiplexed active-low 7-segment bus, rebuilds each scanned digit and reports whole frames.
// Latency: pins->capture 2+STABLE_CYCLES, last capture->o_valid 1; backpressure: none (passive monitor).
module segment_scan_dec
  import segment_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 65536,
  parameter bit AN_ACTIVE_LOW = 1'b1
)(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [6:0]            i_seg,
  input  logic [DIGITS-1:0]     i_an,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [DIGITS-1:0]     o_blank,
  output logic                  o_valid,
  output logic                  o_err,
  output logic                  o_stale
);

  localparam int SEL_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W  = $clog2(STABLE_CYCLES);
  localparam int IDLE_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);
  localparam logic [DIGITS-1:0] AN_IDLE  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  seg_pattern_t      seg_s1, seg_s2;
  logic [DIGITS-1:0] an_s1, an_s2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seg_s1 <= SEG_BLANK;
      seg_s2 <= SEG_BLANK;
      an_s1  <= AN_IDLE;
      an_s2  <= AN_IDLE;
    end else begin
      seg_s1 <= i_seg;
      seg_s2 <= seg_s1;
      an_s1  <= i_an;
      an_s2  <= an_s1;
    end
  end

  logic [DIGITS-1:0] an_act;
  logic              sel_ok;
  logic [SEL_W-1:0]  sel;

  always_comb begin
    an_act = AN_ACTIVE_LOW ? ~an_s2 : an_s2;
    sel_ok = $onehot(an_act);
    sel    = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (an_act[k]) sel = SEL_W'(k);
    end
  end

  // Stability tracking: the (sel,seg) pair must repeat for STABLE_CYCLES before one capture.
  logic              prev_ok;
  logic [SEL_W-1:0]  prev_sel;
  seg_pattern_t      prev_seg;
  logic [CNT_W-1:0]  cnt;
  logic              done;
  logic              same;
  logic              capture;

  assign same    = prev_ok && (prev_sel == sel) && (prev_seg == seg_s2);
  assign capture = sel_ok && same && (cnt == CNT_MAX) && !done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_ok  <= 1'b0;
      prev_sel <= '0;
      prev_seg <= SEG_BLANK;
      cnt      <= '0;
      done     <= 1'b0;
    end else if (!sel_ok) begin
      prev_ok <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
    end else begin
      prev_ok  <= 1'b1;
      prev_sel <= sel;
      prev_seg <= seg_s2;
      if (!same) begin
        cnt  <= '0;
        done <= 1'b0;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        if (capture) done <= 1'b1;
      end
    end
  end

  seg_dec_t dec;

  segment_pattern_dec u_pattern_dec (
    .pat (seg_s2),
    .dec (dec)
  );

  logic [DIGITS-1:0][3:0] staging;
  logic [DIGITS-1:0]      blank_st;
  logic [DIGITS-1:0]      ill_st;
  logic [DIGITS-1:0]      mask;
  logic [IDLE_W-1:0]      idle;
  logic                   frame_done;
  logic                   idle_max;

  assign frame_done = &mask;
  assign idle_max   = (idle == IDLE_MAX);

  // A capture in the same cycle as a frame load or timeout starts the next frame, so it is applied last.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      staging  <= '0;
      blank_st <= '0;
      ill_st   <= '0;
      mask     <= '0;
      idle     <= '0;
      o_bcd    <= '0;
      o_blank  <= '1;
      o_valid  <= 1'b0;
      o_err    <= 1'b0;
      o_stale  <= 1'b1;
    end else begin
      o_valid <= 1'b0;
      if (capture)        idle <= '0;
      else if (!idle_max) idle <= idle + IDLE_W'(1);

      if (frame_done) begin
        o_bcd   <= staging;
        o_blank <= blank_st;
        o_err   <= |ill_st;
        o_valid <= 1'b1;
        o_stale <= 1'b0;
        mask    <= '0;
        ill_st  <= '0;
      end else if (idle_max && !capture) begin
        o_stale  <= 1'b1;
        mask     <= '0;
        staging  <= '0;
        blank_st <= '0;
        ill_st   <= '0;
      end

      if (capture) begin
        staging[sel]  <= dec.value;
        blank_st[sel] <= dec.blank;
        ill_st[sel]   <= dec.illegal;
        mask[sel]     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_segment_scan_dec.sv
// Directed bench for segment_scan_dec: scans digits on an active-low anode bus and checks decoded frames.
module tb_segment_scan_dec;

  localparam int DIGITS  = 4;
  localparam int STABLE  = 4;
  localparam int TIMEOUT = 64;

  localparam logic [6:0] SEG_TAB [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic                 clk;
  logic                 rst_n;
  logic [6:0]           i_seg;
  logic [DIGITS-1:0]    i_an;
  logic [4*DIGITS-1:0]  o_bcd;
  logic [DIGITS-1:0]    o_blank;
  logic                 o_valid;
  logic                 o_err;
  logic                 o_stale;

  int checks;
  int errors;
  int valid_total;
  int v0;

  segment_scan_dec #(
    .DIGITS        (DIGITS),
    .STABLE_CYCLES (STABLE),
    .TIMEOUT       (TIMEOUT),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_seg   (i_seg),
    .i_an    (i_an),
    .o_bcd   (o_bcd),
    .o_blank (o_blank),
    .o_valid (o_valid),
    .o_err   (o_err),
    .o_stale (o_stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every cycle o_valid is high, so a pulse wider than one cycle shows up as an extra count.
  initial valid_total = 0;
  always @(negedge clk) if (o_valid) valid_total = valid_total + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic show_digit(input int k, input logic [6:0] pat, input int n);
    i_an  = ~(4'b0001 << k);
    i_seg = pat;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    i_an  = 4'hF;
    i_seg = 7'h7F;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input int d0, input int d1, input int d2, input int d3);
    show_digit(0, SEG_TAB[d0], 8);
    show_digit(1, SEG_TAB[d1], 8);
    show_digit(2, SEG_TAB[d2], 8);
    show_digit(3, SEG_TAB[d3], 8);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    i_an   = 4'hF;
    i_seg  = 7'h7F;
    repeat (3) @(negedge clk);
    chk("rst_bcd",   32'(o_bcd),   32'h0);
    chk("rst_blank", 32'(o_blank), 32'hF);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_err",   32'(o_err),   32'h0);
    chk("rst_stale", 32'(o_stale), 32'h1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain frame 1,2,3,4.
    v0 = valid_total;
    scan(1, 2, 3, 4);
    idle(4);
    chk("f1_valid", 32'(valid_total - v0), 32'd1);
    chk("f1_bcd",   32'(o_bcd),   32'h4321);
    chk("f1_err",   32'(o_err),   32'h0);
    chk("f1_blank", 32'(o_blank), 32'h0);
    chk("f1_stale", 32'(o_stale), 32'h0);

    // Digit 2 held for STABLE-1 cycles is never captured.
    v0 = valid_total;
    show_digit(0, SEG_TAB[5], 8);
    show_digit(1, SEG_TAB[6], 8);
    show_digit(2, SEG_TAB[7], STABLE - 1);
    show_digit(3, SEG_TAB[8], 8);
    idle(6);
    chk("short_valid", 32'(valid_total - v0), 32'd0);
    chk("short_bcd",   32'(o_bcd), 32'h4321);
    v0 = valid_total;
    scan(5, 6, 7, 8);
    idle(4);
    chk("rescan_valid", 32'(valid_total - v0), 32'd1);
    chk("rescan_bcd",   32'(o_bcd), 32'h8765);
    idle(80);
    chk("idle_stale", 32'(o_stale), 32'h1);
    chk("idle_bcd",   32'(o_bcd),   32'h8765);

    // Blank and illegal patterns.
    v0 = valid_total;
    show_digit(0, 7'h7F, 8);
    show_digit(1, 7'h55, 8);
    show_digit(2, SEG_TAB[9], 8);
    show_digit(3, SEG_TAB[0], 8);
    idle(4);
    chk("bi_valid", 32'(valid_total - v0), 32'd1);
    chk("bi_bcd",   32'(o_bcd),   32'h09EF);
    chk("bi_blank", 32'(o_blank), 32'h1);
    chk("bi_err",   32'(o_err),   32'h1);
    chk("bi_stale", 32'(o_stale), 32'h0);

    // No anode, then two anodes (digits 0 and 1): neither may capture.
    v0 = valid_total;
    i_seg = SEG_TAB[7];
    i_an  = 4'hF;
    repeat (20) @(negedge clk);
    i_an  = 4'b1100;
    repeat (20) @(negedge clk);
    show_digit(2, SEG_TAB[2], 8);
    show_digit(3, SEG_TAB[3], 8);
    idle(4);
    chk("multi_valid", 32'(valid_total - v0), 32'd0);
    show_digit(0, SEG_TAB[0], 8);
    show_digit(1, SEG_TAB[1], 8);
    idle(4);
    chk("after_multi_valid", 32'(valid_total - v0), 32'd1);
    chk("after_multi_bcd",   32'(o_bcd),   32'h3210);
    chk("after_multi_err",   32'(o_err),   32'h0);
    chk("after_multi_blank", 32'(o_blank), 32'h0);

    // Partial frame then timeout: stale rises, o_bcd kept, partial frame dropped.
    v0 = valid_total;
    show_digit(0, SEG_TAB[7], 8);
    show_digit(1, SEG_TAB[8], 8);
    show_digit(2, SEG_TAB[9], 8);
    idle(40);
    chk("to_early_stale", 32'(o_stale), 32'h0);
    idle(30);
    chk("to_stale", 32'(o_stale), 32'h1);
    chk("to_bcd",   32'(o_bcd),   32'h3210);
    chk("to_valid", 32'(valid_total - v0), 32'd0);
    show_digit(3, SEG_TAB[4], 8);
    idle(4);
    chk("to_mask_cleared", 32'(valid_total - v0), 32'd0);
    scan(1, 2, 3, 4);
    idle(4);
    chk("to_recover_valid", 32'(valid_total - v0), 32'd1);
    chk("to_recover_stale", 32'(o_stale), 32'h0);
    chk("to_recover_bcd",   32'(o_bcd),   32'h4321);

    // Reset after three captures discards the partial frame.
    idle(80);
    v0 = valid_total;
    show_digit(0, SEG_TAB[5], 8);
    show_digit(1, SEG_TAB[5], 8);
    show_digit(2, SEG_TAB[5], 8);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mrst_bcd",   32'(o_bcd),   32'h0);
    chk("mrst_blank", 32'(o_blank), 32'hF);
    chk("mrst_stale", 32'(o_stale), 32'h1);
    chk("mrst_err",   32'(o_err),   32'h0);
    rst_n = 1'b1;
    show_digit(3, SEG_TAB[9], 8);
    idle(4);
    chk("mrst_partial_valid", 32'(valid_total - v0), 32'd0);
    show_digit(0, SEG_TAB[1], 8);
    show_digit(1, SEG_TAB[2], 8);
    show_digit(2, SEG_TAB[3], 8);
    idle(4);
    chk("mrst_full_valid", 32'(valid_total - v0), 32'd1);
    chk("mrst_full_bcd",   32'(o_bcd),   32'h9321);
    chk("mrst_full_stale", 32'(o_stale), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
